// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding used by both the
//                transmit and receive sides, ASCII constants and the
//                hex-nibble-to-ASCII character map.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame FSM encoding, shared with uart_rx
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

  // Map a zero-extended value 0..15 onto '0'..'9','A'..'F'
  function automatic logic [7:0] hex_to_ascii(input logic [7:0] n);
    return (n < 8'd10) ? (ASCII_ZERO + n) : (ASCII_A_MINUS_10 + n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_uart_tx_if
//  Description : Bundle between the CPU OUT register side and the UART
//                transmitter: push strobe/data in, serial line and status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface out_uart_tx_if #(
  parameter int REGISTER_WIDTH = 4
);

  logic [REGISTER_WIDTH-1:0] data_i;
  logic                      data_valid_strb_i;
  logic                      tx_o;
  logic                      busy_o;
  logic                      fifo_full_o;
  logic                      overflow_o;

  // CPU side: produces OUT values, observes line and status
  modport master (
    output data_i,
    output data_valid_strb_i,
    input  tx_o,
    input  busy_o,
    input  fifo_full_o,
    input  overflow_o
  );

  // Transmitter side
  modport slave (
    input  data_i,
    input  data_valid_strb_i,
    output tx_o,
    output busy_o,
    output fifo_full_o,
    output overflow_o
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with wrapping pointers and an occupancy
//                counter. dout is the entry at the read pointer (show-ahead),
//                so a pop consumes the value visible in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  wire              clk_i,
  input  wire              reset_i,
  input  wire              push,
  input  wire              pop,
  input  wire  [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // A pop on the same edge frees a slot, so a push while full still lands
  assign w_rd_en = pop & ~empty;
  assign w_wr_en = push & (~full | w_rd_en);

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/out_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : out_uart_tx
//  Description : Queues CPU OUT nibbles, converts each to an ASCII hex
//                character and transmits it as a UART 8N1 frame, LSB first.
//                A FIFO absorbs bursts faster than the line rate.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_uart_tx
  import uart_pkg::*;
#(
  parameter int REGISTER_WIDTH             = 4,
  parameter int UART_DATA_LENGTH           = 8,
  parameter int BAUD_COUNTS_PER_BIT        = 521,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = 10,
  parameter int TX_COUNTER_BITWIDTH        = 3,
  parameter int FIFO_DEPTH                 = 8,
  parameter int FIFO_ADDR_WIDTH            = 3
) (
  input  wire          clk_i,
  input  wire          reset_i,
  out_uart_tx_if.slave bus
);

  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] C_BAUD_LAST =
    BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);
  localparam logic [TX_COUNTER_BITWIDTH-1:0] C_BIT_LAST =
    TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);

  logic [1:0]                            r_state;
  logic [1:0]                            w_state_next;
  logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] r_baud_cnt;
  logic [TX_COUNTER_BITWIDTH-1:0]        r_bit_idx;
  logic [UART_DATA_LENGTH-1:0]           r_shift;
  logic                                  r_tx;
  logic                                  r_overflow;

  logic [REGISTER_WIDTH-1:0]             w_fifo_dout;
  logic                                  w_fifo_full;
  logic                                  w_fifo_empty;
  logic                                  w_pop;
  logic                                  w_bit_end;
  logic                                  w_last_bit;
  logic                                  w_tx_next;
  logic                                  w_drop;
  logic [UART_DATA_LENGTH-1:0]           w_char;

  sync_fifo #(
    .WIDTH      (REGISTER_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (bus.data_valid_strb_i),
    .pop     (w_pop),
    .din     (bus.data_i),
    .dout    (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign w_char     = UART_DATA_LENGTH'(hex_to_ascii(8'(w_fifo_dout)));
  assign w_bit_end  = (r_baud_cnt == C_BAUD_LAST);
  assign w_last_bit = (r_bit_idx == C_BIT_LAST);
  // A push is lost only when the FIFO is full and nothing leaves this edge
  assign w_drop     = bus.data_valid_strb_i & w_fifo_full & ~w_pop;

  assign bus.tx_o        = r_tx;
  assign bus.busy_o      = (r_state != IDLE) | ~w_fifo_empty;
  assign bus.fifo_full_o = w_fifo_full;
  assign bus.overflow_o  = r_overflow;

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: each non-idle state lasts whole bit periods
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty)             w_state_next = START;
      START:   if (w_bit_end)                 w_state_next = DATA;
      DATA:    if (w_bit_end && w_last_bit)   w_state_next = STOP;
      STOP:    if (w_bit_end)                 w_state_next = IDLE;
      default:                                w_state_next = IDLE;
    endcase
  end

  // FSM outputs: FIFO pop and the line level for the next cycle
  always_comb begin
    w_pop     = 1'b0;
    w_tx_next = 1'b1;
    case (r_state)
      IDLE: begin
        w_pop     = ~w_fifo_empty;
        w_tx_next = w_fifo_empty;
      end
      START:   w_tx_next = w_bit_end ? r_shift[0] : 1'b0;
      // r_shift[1] is the bit that becomes shift[0] after this boundary
      DATA:    w_tx_next = w_bit_end ? (w_last_bit ? 1'b1 : r_shift[1]) : r_shift[0];
      STOP:    w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

  // Baud counter restarts at every bit boundary and is held at zero in IDLE
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_baud_cnt <= '0;
    end else if (r_state == IDLE || w_bit_end) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + BAUD_RATE_COUNTER_BITWIDTH'(1);
    end
  end

  // Shift register and data-bit index
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bit_idx <= '0;
          if (w_pop) begin
            r_shift <= w_char;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + TX_COUNTER_BITWIDTH'(1);
          end
        end
        default: begin
          r_bit_idx <= r_bit_idx;
        end
      endcase
    end
  end

  // Registered line driver and sticky overflow flag
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_tx <= w_tx_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_out_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_uart_tx
//  Description : Directed self-checking bench for out_uart_tx with a short
//                bit period (4 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_uart_tx;

  localparam int BAUD = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;

  out_uart_tx_if #(.REGISTER_WIDTH(4)) bus ();

  out_uart_tx #(
    .REGISTER_WIDTH             (4),
    .UART_DATA_LENGTH           (8),
    .BAUD_COUNTS_PER_BIT        (BAUD),
    .BAUD_RATE_COUNTER_BITWIDTH (2),
    .TX_COUNTER_BITWIDTH        (3),
    .FIFO_DEPTH                 (8),
    .FIFO_ADDR_WIDTH            (3)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reset pulse, released on a falling edge
  task automatic do_reset();
    @(negedge clk);
    bus.data_valid_strb_i = 1'b0;
    bus.data_i            = 4'h0;
    reset_n               = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Serial receiver: waits for a low line, samples mid-bit, checks stop bit.
  // Returns in the middle of the stop bit.
  task automatic rx_char(output logic [7:0] ch, output bit ok);
    int w;
    w  = 0;
    ch = 8'h00;
    ok = 1'b1;
    while (bus.tx_o !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      ok = 1'b0;
    end else begin
      repeat (2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (BAUD) @(negedge clk);
        ch[b] = bus.tx_o;
      end
      repeat (BAUD) @(negedge clk);
      if (bus.tx_o !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.tx_o !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", bus.tx_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.fifo_full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.fifo_full_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_o); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [9:0] exp_line;
    exp_line = {1'b1, 8'h37, 1'b0};
    do_reset();
    bus.data_i            = 4'h7;
    bus.data_valid_strb_i = 1'b1;
    @(negedge clk);
    bus.data_valid_strb_i = 1'b0;
    n_cmp++; if (bus.tx_o !== 1'b1) begin n_err++; $display("FAIL single_pre_tx: got %b want 1", bus.tx_o); end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", bus.busy_o); end
    for (int i = 0; i < 10 * BAUD; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.tx_o !== exp_line[i / BAUD]) begin
        n_err++;
        $display("FAIL single_line cycle %0d: got %b want %b", i, bus.tx_o, exp_line[i / BAUD]);
      end
    end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy_stop: got %b want 1", bus.busy_o); end
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.tx_o !== 1'b1) begin n_err++; $display("FAIL single_idle_tx: got %b want 1", bus.tx_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ch;
    bit         ok;
    do_reset();
    bus.data_i            = 4'hA;
    bus.data_valid_strb_i = 1'b1;
    @(negedge clk);
    bus.data_i = 4'hF;
    @(negedge clk);
    bus.data_valid_strb_i = 1'b0;
    n_cmp++; if (bus.tx_o !== 1'b0) begin n_err++; $display("FAIL b2b_start: got %b want 0", bus.tx_o); end
    rx_char(ch, ok);
    n_cmp++; if (!ok || ch !== 8'h41) begin n_err++; $display("FAIL b2b_char_a: got %h ok=%0d want 41", ch, ok); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.tx_o !== 1'b1) begin n_err++; $display("FAIL b2b_gap: got %b want 1", bus.tx_o); end
    @(negedge clk);
    n_cmp++; if (bus.tx_o !== 1'b0) begin n_err++; $display("FAIL b2b_second_start: got %b want 0", bus.tx_o); end
    rx_char(ch, ok);
    n_cmp++; if (!ok || ch !== 8'h46) begin n_err++; $display("FAIL b2b_char_f: got %h ok=%0d want 46", ch, ok); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_overflow();
    logic [7:0] got [9];
    bit         oks [9];
    int         bad;
    do_reset();
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          bus.data_i            = 4'(k);
          bus.data_valid_strb_i = 1'b1;
          @(negedge clk);
          if (k == 7) begin
            n_cmp++; if (bus.fifo_full_o !== 1'b0) begin n_err++; $display("FAIL ovf_full_7: got %b want 0", bus.fifo_full_o); end
          end
          if (k == 8) begin
            n_cmp++; if (bus.fifo_full_o !== 1'b1) begin n_err++; $display("FAIL ovf_full_9th: got %b want 1", bus.fifo_full_o); end
            n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", bus.overflow_o); end
          end
          if (k == 9) begin
            n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.overflow_o); end
            n_cmp++; if (bus.fifo_full_o !== 1'b1) begin n_err++; $display("FAIL ovf_full_held: got %b want 1", bus.fifo_full_o); end
          end
        end
        bus.data_valid_strb_i = 1'b0;
      end
      begin
        for (int j = 0; j < 9; j++) begin
          rx_char(got[j], oks[j]);
        end
      end
    join
    for (int j = 0; j < 9; j++) begin
      n_cmp++;
      if (!oks[j] || got[j] !== 8'h30 + 8'(j)) begin
        n_err++;
        $display("FAIL ovf_char %0d: got %h ok=%0d want %h", j, got[j], oks[j], 8'h30 + 8'(j));
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL ovf_drain_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o); end
    n_cmp++; if (bus.fifo_full_o !== 1'b0) begin n_err++; $display("FAIL ovf_drain_full: got %b want 0", bus.fifo_full_o); end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.tx_o !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ovf_no_tenth: got %0d low cycles want 0", bad); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_c [9];
    logic [7:0] ch;
    bit         ok;
    exp_c = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h43};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bus.data_i            = 4'(k);
      bus.data_valid_strb_i = 1'b1;
      @(negedge clk);
    end
    bus.data_valid_strb_i = 1'b0;
    n_cmp++; if (bus.fifo_full_o !== 1'b1) begin n_err++; $display("FAIL fp_filled: got %b want 1", bus.fifo_full_o); end
    // First frame ends after 40 line cycles; cycle 42 is the single idle cycle
    repeat (33) @(negedge clk);
    n_cmp++; if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b1) begin n_err++; $display("FAIL fp_idle: got tx=%b busy=%b want 1/1", bus.tx_o, bus.busy_o); end
    bus.data_i            = 4'hC;
    bus.data_valid_strb_i = 1'b1;
    @(negedge clk);
    bus.data_valid_strb_i = 1'b0;
    n_cmp++; if (bus.fifo_full_o !== 1'b1) begin n_err++; $display("FAIL fp_full_held: got %b want 1", bus.fifo_full_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL fp_no_ovf: got %b want 0", bus.overflow_o); end
    n_cmp++; if (bus.tx_o !== 1'b0) begin n_err++; $display("FAIL fp_start: got %b want 0", bus.tx_o); end
    for (int j = 0; j < 9; j++) begin
      rx_char(ch, ok);
      n_cmp++;
      if (!ok || ch !== exp_c[j]) begin
        n_err++;
        $display("FAIL fp_char %0d: got %h ok=%0d want %h", j, ch, ok, exp_c[j]);
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL fp_end: got busy=%b ovf=%b want 0/0", bus.busy_o, bus.overflow_o); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    do_reset();
    bus.data_i            = 4'h7;
    bus.data_valid_strb_i = 1'b1;
    @(negedge clk);
    bus.data_i = 4'h5;
    @(negedge clk);
    bus.data_valid_strb_i = 1'b0;
    // Line cycle 17 from start = data bit 3 of 8'h37, which is 0
    repeat (17) @(negedge clk);
    n_cmp++; if (bus.tx_o !== 1'b0) begin n_err++; $display("FAIL rmf_bit3: got %b want 0", bus.tx_o); end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.tx_o !== 1'b1) begin n_err++; $display("FAIL rmf_tx: got %b want 1", bus.tx_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rmf_busy: got %b want 0", bus.busy_o); end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rmf_quiet: got %0d active cycles want 0", bad); end
  endtask

  initial begin
    bus.data_i            = 4'h0;
    bus.data_valid_strb_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
